sequence_gen_tx: RTL and testbench

//   Serial pattern transmitter: the driving end of the sequence_in bit line.

---
 rtl/seq_defs.sv | 20 ++
 rtl/sequence_gen_tx_if.sv | 29 ++
 rtl/seq_shift_reg.sv | 28 ++
 rtl/sequence_gen_tx.sv | 166 ++++++++++++++++
 tb/tb_sequence_gen_tx.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/seq_defs.sv
// Shared definitions for the sequence generator/detector pair.
// Holds the FSM state encodings and the default pattern constant.
package seq_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  localparam int         SEQ_PAT_W_DEFAULT = 4;
  localparam logic [3:0] SEQ_PAT_DEFAULT   = 4'b1011;

  // Width of a down-counter that must hold PAT_W-1; never narrower than one bit.
  function automatic int bitCntWidth(input int patW);
    return (patW <= 2) ? 1 : $clog2(patW);
  endfunction

endpackage

// File: rtl/sequence_gen_tx_if.sv
// Control/status bundle of the serial pattern transmitter.
// The master drives the request side; the slave (transmitter) drives the serial/status side.
interface sequence_gen_tx_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
);

  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] rep_cnt;
  logic [GAP_W-1:0] gap_len;
  logic             sequence_out;
  logic             seq_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pattern, rep_cnt, gap_len,
    input  sequence_out, seq_valid, busy, done
  );

  modport slave (
    input  start, abort, pattern, rep_cnt, gap_len,
    output sequence_out, seq_valid, busy, done
  );

endinterface

// File: rtl/seq_shift_reg.sv
// PAT_W-bit parallel-load shift register, MSB-first; load wins over shift.
// The vacated LSB fills with zero so a drained register reads all zeros.
module seq_shift_reg #(
  parameter int PAT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [PAT_W-1:0] data_i,
  output logic             msb_o
);

  logic [PAT_W-1:0] shReg_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shReg_q <= '0;
    end else if (load_i) begin
      shReg_q <= data_i;
    end else if (shift_i) begin
      shReg_q <= {shReg_q[PAT_W-2:0], 1'b0};
    end
  end

  assign msb_o = shReg_q[PAT_W-1];

endmodule

// File: rtl/sequence_gen_tx.sv
// Serial pattern transmitter: sends a captured PAT_W-bit pattern MSB-first rep_cnt times.
// Optional feature macro SEQ_GEN_GAP_EN inserts gap_len zero cycles between repetitions.
module sequence_gen_tx
  import seq_defs::*;
#(
  parameter int PAT_W = SEQ_PAT_W_DEFAULT,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input logic              clock,
  input logic              reset,
  sequence_gen_tx_if.slave bus
);

  localparam int              BC_W    = bitCntWidth(PAT_W);
  localparam logic [BC_W-1:0] BIT_MSB = BC_W'(PAT_W - 1);

  seq_state_e       state_q, state_d;
  logic [BC_W-1:0]  bitCnt_q, bitCnt_d;
  logic [CNT_W-1:0] repCnt_q, repCnt_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic             seqOut_q, seqValid_q, busy_q, done_q;
  logic             srLoad, srShift, srMsb;
  logic [PAT_W-1:0] srData;

`ifdef SEQ_GEN_GAP_EN
  logic [GAP_W-1:0] gapLen_q, gapLen_d;
  logic [GAP_W-1:0] gapCnt_q, gapCnt_d;
`else
  logic [GAP_W-1:0] unused_gapLen;
  assign unused_gapLen = bus.gap_len;
`endif

  seq_shift_reg #(.PAT_W(PAT_W)) u_shift (
    .clock   (clock),
    .reset   (reset),
    .load_i  (srLoad),
    .shift_i (srShift),
    .data_i  (srData),
    .msb_o   (srMsb)
  );

  // Next-state logic; a reload of the shift register restarts the bit counter at the MSB.
  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q;
    repCnt_d  = repCnt_q;
    pattern_d = pattern_q;
    srLoad    = 1'b0;
    srShift   = 1'b0;
    srData    = pattern_q;
`ifdef SEQ_GEN_GAP_EN
    gapLen_d  = gapLen_q;
    gapCnt_d  = gapCnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          pattern_d = bus.pattern;
          repCnt_d  = bus.rep_cnt;
`ifdef SEQ_GEN_GAP_EN
          gapLen_d  = bus.gap_len;
`endif
          if (bus.rep_cnt != '0) begin
            state_d  = ST_SHIFT;
            srLoad   = 1'b1;
            srData   = bus.pattern;
            bitCnt_d = BIT_MSB;
          end else begin
            state_d  = ST_DONE;
          end
        end
      end

      ST_SHIFT: begin
        srShift  = 1'b1;
        bitCnt_d = bitCnt_q - 1'b1;
        if (bitCnt_q == '0) begin
          if (repCnt_q > CNT_W'(1)) begin
            repCnt_d = repCnt_q - 1'b1;
`ifdef SEQ_GEN_GAP_EN
            if (gapLen_q != '0) begin
              state_d  = ST_GAP;
              gapCnt_d = gapLen_q - 1'b1;
            end else begin
              srLoad   = 1'b1;
              bitCnt_d = BIT_MSB;
            end
`else
            srLoad   = 1'b1;
            bitCnt_d = BIT_MSB;
`endif
          end else begin
            repCnt_d = '0;
            state_d  = ST_DONE;
          end
        end
      end

      ST_GAP: begin
`ifdef SEQ_GEN_GAP_EN
        if (gapCnt_q == '0) begin
          state_d  = ST_SHIFT;
          srLoad   = 1'b1;
          bitCnt_d = BIT_MSB;
        end else begin
          gapCnt_d = gapCnt_q - 1'b1;
        end
`else
        state_d = ST_IDLE;
`endif
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  // Outputs are registered from the current state, so bits trail the state by one clock;
  // busy follows the next state so it drops in the same cycle done rises.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      bitCnt_q   <= '0;
      repCnt_q   <= '0;
      pattern_q  <= '0;
      seqOut_q   <= 1'b0;
      seqValid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SEQ_GEN_GAP_EN
      gapLen_q   <= '0;
      gapCnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      repCnt_q   <= repCnt_d;
      pattern_q  <= pattern_d;
      seqValid_q <= (state_q == ST_SHIFT) && !bus.abort;
      seqOut_q   <= (state_q == ST_SHIFT) && !bus.abort && srMsb;
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_q == ST_DONE) && !bus.abort;
`ifdef SEQ_GEN_GAP_EN
      gapLen_q   <= gapLen_d;
      gapCnt_q   <= gapCnt_d;
`endif
    end
  end

  assign bus.sequence_out = seqOut_q;
  assign bus.seq_valid    = seqValid_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_sequence_gen_tx.sv
// Self-checking bench for sequence_gen_tx: table-driven transfers scored against a cycle queue,
// plus hand-written busy-start, abort and mid-transfer reset sequences.
module tb_sequence_gen_tx;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int GAP_W = 4;
`ifdef SEQ_GEN_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  typedef struct {
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repCnt;
    logic [GAP_W-1:0] gapLen;
    int               expValid;
    string            name;
  } vec_t;

  logic clock;
  logic reset;
  int   nCompared   = 0;
  int   nMismatched = 0;
  int   validSeen   = 0;

  // Each entry is {seq_valid, sequence_out, busy, done} expected at one falling edge.
  logic [3:0] expQ[$];
  vec_t       vecs[8];

  sequence_gen_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

  sequence_gen_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required finished", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compare(input string name, input logic [3:0] got, input logic [3:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got {valid,out,busy,done}=%b required %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compareInt(input string name, input int got, input int exp);
    nCompared++;
    if (got != exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // Reference model of one accepted start: a busy-only cycle, the bits, optional gaps, done.
  function automatic void pushModel(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] rep,
                                    input logic [GAP_W-1:0] gap);
    expQ.push_back(4'b0010);
    for (int r = 0; r < int'(rep); r++) begin
      for (int i = PAT_W - 1; i >= 0; i--) expQ.push_back({1'b1, pat[i], 1'b1, 1'b0});
      if (GAP_ON && (r != int'(rep) - 1))
        for (int g = 0; g < int'(gap); g++) expQ.push_back(4'b0010);
    end
    expQ.push_back(4'b0001);
  endfunction

  // Called just after a falling edge; start is sampled at the next rising edge.
  task automatic applyStimulus(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] rep,
                               input logic [GAP_W-1:0] gap);
    bus.pattern = pat;
    bus.rep_cnt = rep;
    bus.gap_len = gap;
    bus.start   = 1'b1;
    pushModel(pat, rep, gap);
    @(posedge clock);
    #1;
    bus.start   = 1'b0;
    bus.pattern = PAT_W'($urandom);
    bus.rep_cnt = CNT_W'($urandom);
    bus.gap_len = GAP_W'($urandom);
  endtask

  task automatic checkOutput(input string name);
    logic [3:0] got;
    logic [3:0] exp;
    @(negedge clock);
    got = {bus.seq_valid, bus.sequence_out, bus.busy, bus.done};
    if (got[3]) validSeen++;
    if (expQ.size() == 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL %s: got %b with no expectation queued", name, got);
    end else begin
      exp = expQ.pop_front();
      compare(name, got, exp);
    end
  endtask

  task automatic drainQueue(input string name);
    while (expQ.size() > 0) checkOutput(name);
  endtask

  task automatic checkIdle(input string name);
    expQ.push_back(4'b0000);
    checkOutput(name);
  endtask

  initial begin
    vecs[0] = '{4'b1011, 8'd1,   4'd0, 4,    "single 1011"};
    vecs[1] = '{4'b1011, 8'd3,   4'd2, 12,   "triple 1011"};
    vecs[2] = '{4'b0110, 8'd2,   4'd1, 8,    "double 0110"};
    vecs[3] = '{4'b1111, 8'd1,   4'd0, 4,    "all ones"};
    vecs[4] = '{4'b0000, 8'd2,   4'd3, 8,    "all zeros"};
    vecs[5] = '{4'b1000, 8'd0,   4'd2, 0,    "zero reps"};
    vecs[6] = '{4'b0001, 8'd4,   4'd3, 16,   "quad 0001"};
    vecs[7] = '{4'b1010, 8'd255, 4'd0, 1020, "max reps"};

    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.pattern = '0;
    bus.rep_cnt = '0;
    bus.gap_len = '0;
    reset       = 1'b1;
    #2 reset = 1'b0;
    #1 compare("reset state", {bus.seq_valid, bus.sequence_out, bus.busy, bus.done}, 4'b0000);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    checkIdle("idle after reset");

    foreach (vecs[v]) begin
      validSeen = 0;
      applyStimulus(vecs[v].pattern, vecs[v].repCnt, vecs[v].gapLen);
      drainQueue(vecs[v].name);
      checkIdle({vecs[v].name, " idle"});
      compareInt({vecs[v].name, " valid bits"}, validSeen, vecs[v].expValid);
    end

    // Start with a new pattern during a transfer is ignored; start in the IDLE cycle after done is taken.
    applyStimulus(4'b1011, 8'd1, 4'd0);
    checkOutput("busy start pre");
    checkOutput("busy start bit3");
    bus.start   = 1'b1;
    bus.pattern = 4'b0110;
    bus.rep_cnt = 8'd5;
    checkOutput("busy start bit2");
    bus.start   = 1'b0;
    drainQueue("busy start tail");
    applyStimulus(4'b0110, 8'd1, 4'd0);
    drainQueue("restart after done");
    checkIdle("restart idle");

    // Abort after the second bit: everything drops next cycle and done never pulses.
    applyStimulus(4'b1011, 8'd2, 4'd0);
    checkOutput("abort pre");
    checkOutput("abort bit3");
    checkOutput("abort bit2");
    bus.abort = 1'b1;
    expQ.delete();
    repeat (3) expQ.push_back(4'b0000);
    checkOutput("abort first");
    bus.abort = 1'b0;
    drainQueue("abort no done");

    // Asynchronous reset mid-transfer clears outputs before any clock edge.
    applyStimulus(4'b1111, 8'd3, 4'd0);
    checkOutput("reset mid pre");
    checkOutput("reset mid bit3");
    #2 reset = 1'b0;
    #1 compare("reset mid async", {bus.seq_valid, bus.sequence_out, bus.busy, bus.done}, 4'b0000);
    @(negedge clock);
    reset = 1'b1;
    expQ.delete();
    checkIdle("reset mid idle");
    applyStimulus(4'b0101, 8'd1, 4'd0);
    drainQueue("after reset");
    checkIdle("after reset idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
